// File: rtl/rx_mem_wr_sched_pkg.sv
// rx_mem_wr_sched_pkg: FSM encoding and buffer layout constants shared by the rx audio write path
package rx_mem_wr_sched_pkg;
   typedef enum logic [3:0] {IDLE, GETI, WAITI, WRI, GETQ, WAITQ, WRQ, TS, DONE} state_t;
   localparam int TS_WORDS = 3;
   localparam int WORD_W = 16;
endpackage

// File: rtl/rx_wr_addr_gen.sv
// rx_wr_addr_gen: word pointer within the current buffer plus ring index and completed-buffer count
module rx_wr_addr_gen #(
   parameter int BUF_WORDS = 2048,
   parameter int NBUF = 2,
   parameter int AW = 12,
   parameter int IW = 1
) (
   input  logic          adc_clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          inc,
   input  logic          next_buf,
   output logic [AW-1:0] addr,
   output logic [IW-1:0] buf_idx,
   output logic [15:0]   buf_ctr
);
   localparam int PW = BUF_WORDS > 1 ? $clog2(BUF_WORDS) : 1;
   logic [PW-1:0] ptr;
   assign addr = AW'(buf_idx) * AW'(BUF_WORDS) + AW'(ptr);
   always_ff @(posedge adc_clk or posedge reset)
      if (reset) begin
         ptr     <= '0;
         buf_idx <= '0;
         buf_ctr <= '0;
      end else if (clear) begin
         ptr     <= '0;
         buf_idx <= '0;
         buf_ctr <= '0;
      end else if (next_buf) begin
         ptr     <= '0;
         buf_idx <= buf_idx == IW'(NBUF - 1) ? '0 : buf_idx + 1'b1;
         buf_ctr <= buf_ctr + 1'b1;
      end else if (inc)
         // oversized buffers wrap inside themselves rather than spilling into the next one
         ptr <= ptr == PW'(BUF_WORDS - 1) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/rx_mem_wr_sched.sv
// rx_mem_wr_sched: strobes the DDC array for I then Q words and writes them, plus a tick stamp,
// into a ring of sample buffers in the rx audio memory
module rx_mem_wr_sched
   import rx_mem_wr_sched_pkg::*;
#(
   parameter int CHANS = 4,
   parameter int GET_LAT = 1,
   parameter int BUF_WORDS = 2048,
   parameter int NBUF = 2,
   parameter int AW = 12,
   localparam int IW = NBUF > 1 ? $clog2(NBUF) : 1
) (
   input  logic                adc_clk,
   input  logic                reset,
   input  logic                rx_avail,
   input  logic [CHANS*16-1:0] rxn_din,
   input  logic [7:0]          nrx_samps,
   input  logic [47:0]         ticks,
   input  logic                buf_rst,
   output logic                rd_getI,
   output logic                rd_getQ,
   output logic                mem_wr,
   output logic [AW-1:0]       mem_waddr,
   output logic [15:0]         mem_wdata,
   output logic                srq,
   output logic [IW-1:0]       buf_idx,
   output logic [15:0]         buf_ctr,
   output logic                ovfl
);
   localparam int CW = CHANS > 1 ? $clog2(CHANS) : 1;
   localparam int WW = $clog2(GET_LAT + 1);
   typedef struct packed {
      state_t             st;
      logic [CW-1:0]      ch;
      logic [WW-1:0]      wc;
      logic [1:0]         tsi;
      logic [7:0]         cnt;
      logic [47:0]        ts;
      logic               rd_geti;
      logic               rd_getq;
      logic               srq;
      logic               ovfl;
      logic               mem_wr;
      logic [AW-1:0]      mem_waddr;
      logic [WORD_W-1:0]  mem_wdata;
   } regs_t;
   regs_t r, n;
   logic wr, nb;
   logic [WORD_W-1:0] wd;
   logic [AW-1:0] addr;
   logic [CW-1:0] chn;
   assign chn = r.ch + 1'b1;
   rx_wr_addr_gen #(.BUF_WORDS(BUF_WORDS), .NBUF(NBUF), .AW(AW), .IW(IW)) u_addr (
      .adc_clk  (adc_clk),
      .reset    (reset),
      .clear    (buf_rst),
      .inc      (wr),
      .next_buf (nb),
      .addr     (addr),
      .buf_idx  (buf_idx),
      .buf_ctr  (buf_ctr)
   );
   // every write is decided one cycle early so mem_wr is high exactly while the FSM sits in WR*/TS
   always_comb begin
      n = r;
      n.rd_geti = 1'b0;
      n.rd_getq = 1'b0;
      n.srq = 1'b0;
      n.mem_wr = 1'b0;
      wr = 1'b0;
      wd = '0;
      nb = 1'b0;
      if (rx_avail && r.st != IDLE) n.ovfl = 1'b1;
      case (r.st)
         IDLE: if (rx_avail && nrx_samps != 8'd0) begin
            n.st = GETI;
            n.rd_geti = 1'b1;
            n.ts = ticks;
         end
         GETI, GETQ: begin
            n.st = r.st == GETI ? WAITI : WAITQ;
            n.wc = '0;
         end
         WAITI, WAITQ: if (r.wc == WW'(GET_LAT - 1)) begin
            n.st = r.st == WAITI ? WRI : WRQ;
            n.ch = '0;
            wr = 1'b1;
            wd = rxn_din[15:0];
         end else n.wc = r.wc + 1'b1;
         WRI, WRQ: if (r.ch != CW'(CHANS - 1)) begin
            n.ch = chn;
            wr = 1'b1;
            wd = rxn_din[16*chn +: 16];
         end else if (r.st == WRI) begin
            n.st = GETQ;
            n.rd_getq = 1'b1;
         end else begin
            n.cnt = r.cnt + 1'b1;
            n.st = r.cnt + 8'd1 == nrx_samps ? TS : IDLE;
            n.tsi = '0;
            wr = r.cnt + 8'd1 == nrx_samps;
            wd = r.ts[15:0];
         end
         TS: if (r.tsi != 2'(TS_WORDS - 1)) begin
            n.tsi = r.tsi + 1'b1;
            wr = 1'b1;
            wd = r.tsi == 2'd0 ? r.ts[31:16] : r.ts[47:32];
         end else begin
            n.st = DONE;
            n.srq = 1'b1;
            nb = 1'b1;
         end
         DONE: begin
            n.st = IDLE;
            n.cnt = '0;
         end
         default: n.st = IDLE;
      endcase
      if (wr) begin
         n.mem_wr = 1'b1;
         n.mem_wdata = wd;
         n.mem_waddr = addr;
      end
      if (buf_rst) begin
         n = '0;
         wr = 1'b0;
         nb = 1'b0;
      end
   end
   always_ff @(posedge adc_clk or posedge reset)
      if (reset) r <= '0;
      else r <= n;
   assign rd_getI = r.rd_geti;
   assign rd_getQ = r.rd_getq;
   assign srq = r.srq;
   assign ovfl = r.ovfl;
   assign mem_wr = r.mem_wr;
   assign mem_waddr = r.mem_waddr;
   assign mem_wdata = r.mem_wdata;
endmodule

// File: tb/tb_rx_mem_wr_sched.sv
// tb_rx_mem_wr_sched: scoreboard bench for the rx sample buffer write scheduler
module tb_rx_mem_wr_sched;
   localparam int CHANS = 4, GET_LAT = 1, BW = 64, NBUF = 2, AW = 12;
   logic adc_clk = 0, reset = 1, rx_avail = 0, buf_rst = 0;
   logic [CHANS*16-1:0] rxn_din = '0;
   logic [7:0] nrx_samps = 8'd2;
   logic [47:0] ticks = 48'hA5A5_1234_0F00;
   logic rd_getI, rd_getQ, mem_wr, srq, ovfl;
   logic [AW-1:0] mem_waddr;
   logic [15:0] mem_wdata, buf_ctr;
   logic [0:0] buf_idx;
   int tests = 0, fails = 0;
   int cyc = 0, n_wr = 0, n_get = 0, n_srq = 0, srq_cyc = 0, last_wr_cyc = 0;
   bit sb_en = 1;
   logic [AW+15:0] q[$];
   int exp_ptr = 0, exp_idx = 0, exp_ctr = 0, exp_cnt = 0;

   rx_mem_wr_sched #(.CHANS(CHANS), .GET_LAT(GET_LAT), .BUF_WORDS(BW), .NBUF(NBUF), .AW(AW)) dut (
      .adc_clk(adc_clk), .reset(reset), .rx_avail(rx_avail), .rxn_din(rxn_din),
      .nrx_samps(nrx_samps), .ticks(ticks), .buf_rst(buf_rst), .rd_getI(rd_getI),
      .rd_getQ(rd_getQ), .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .srq(srq), .buf_idx(buf_idx), .buf_ctr(buf_ctr), .ovfl(ovfl));

   always #5 adc_clk = ~adc_clk;
   initial forever begin
      @(negedge adc_clk);
      ticks = ticks + 1;
   end

   // DDC array model: words become valid one cycle after the strobe
   initial forever begin
      logic ph;
      @(negedge adc_clk);
      if (rd_getI || rd_getQ) begin
         ph = rd_getQ;
         @(posedge adc_clk);
         #1;
         for (int k = 0; k < CHANS; k++) rxn_din[16*k +: 16] = 16'hC000 | 16'(k << 4) | 16'(ph);
      end
   end

   // write monitor and scoreboard comparator
   initial forever begin
      logic [AW+15:0] e;
      @(negedge adc_clk);
      cyc++;
      if (rd_getI || rd_getQ) begin
         n_get++;
         tests++;
         if (rd_getI && rd_getQ) begin fails++; $display("FAIL get_excl: rd_getI and rd_getQ both high at cycle %0d", cyc); end
      end
      if (srq) begin n_srq++; srq_cyc = cyc; end
      if (mem_wr) begin
         n_wr++;
         last_wr_cyc = cyc;
         if (sb_en) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL wr_unexp: write addr %0d data %h with nothing expected", mem_waddr, mem_wdata);
            end else begin
               e = q.pop_front();
               if ({mem_waddr, mem_wdata} !== e) begin
                  fails++;
                  $display("FAIL wr_word: got addr %0d data %h, want addr %0d data %h", mem_waddr, mem_wdata, e[AW+15:16], e[15:0]);
               end
            end
         end
      end
   end

   task automatic push_word(input logic [15:0] d);
      q.push_back({AW'(exp_idx * BW + exp_ptr), d});
      exp_ptr = (exp_ptr + 1) % BW;
   endtask

   task automatic push_sample(input logic [47:0] tk);
      for (int p = 0; p < 2; p++)
         for (int k = 0; k < CHANS; k++) push_word(16'hC000 | 16'(k << 4) | 16'(p));
      exp_cnt++;
      if (exp_cnt == int'(nrx_samps)) begin
         push_word(tk[15:0]);
         push_word(tk[31:16]);
         push_word(tk[47:32]);
         exp_idx = (exp_idx + 1) % NBUF;
         exp_ctr++;
         exp_ptr = 0;
         exp_cnt = 0;
      end
   endtask

   task automatic model_clear();
      exp_ptr = 0; exp_idx = 0; exp_ctr = 0; exp_cnt = 0;
      q.delete();
   endtask

   task automatic pulse(output logic [47:0] tk);
      @(posedge adc_clk); #1 rx_avail = 1;
      @(posedge adc_clk); tk = ticks;
      #1 rx_avail = 0;
   endtask

   task automatic send_sample();
      logic [47:0] tk;
      pulse(tk);
      push_sample(tk);
   endtask

   task automatic drain();
      int b = 0;
      while (q.size() != 0 && b < 300) begin @(negedge adc_clk); b++; end
      tests++;
      if (q.size() != 0) begin fails++; $display("FAIL drain: %0d expected writes never appeared", q.size()); end
      repeat (6) @(negedge adc_clk);
   endtask

   task automatic buf_rst_pulse();
      @(posedge adc_clk); #1 buf_rst = 1;
      @(posedge adc_clk); #1 buf_rst = 0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge adc_clk);
      tests++;
      if ({rd_getI, rd_getQ, mem_wr, mem_waddr, mem_wdata, srq, buf_idx, buf_ctr, ovfl} !== '0) begin
         fails++; $display("FAIL reset_outs: outputs not zero in reset, mem_waddr=%0d buf_ctr=%0d", mem_waddr, buf_ctr);
      end
      @(posedge adc_clk); #1 reset = 0;
      repeat (3) @(negedge adc_clk);
      tests++;
      if ({rd_getI, mem_wr, srq, buf_idx, buf_ctr, ovfl} !== '0) begin
         fails++; $display("FAIL reset_idle: outputs not zero after release");
      end
   endtask

   task automatic test_fill();
      int s0;
      s0 = n_srq;
      send_sample();
      @(negedge adc_clk);
      tests++;
      if (rd_getI !== 1'b1) begin fails++; $display("FAIL geti_lat: rd_getI=%b want 1 one cycle after rx_avail", rd_getI); end
      repeat (6) @(negedge adc_clk);
      tests++;
      if (rd_getQ !== 1'b1) begin fails++; $display("FAIL getq_lat: rd_getQ=%b want 1 six cycles after rd_getI", rd_getQ); end
      repeat (12) @(posedge adc_clk);
      send_sample();
      drain();
      tests++;
      if (n_srq - s0 != 1) begin fails++; $display("FAIL srq_cnt: %0d pulses want 1", n_srq - s0); end
      tests++;
      if (srq_cyc != last_wr_cyc + 1) begin fails++; $display("FAIL srq_time: srq at %0d want %0d", srq_cyc, last_wr_cyc + 1); end
      tests++;
      if (buf_ctr !== 16'(exp_ctr) || buf_idx !== 1'(exp_idx)) begin
         fails++; $display("FAIL fill_ctrs: buf_ctr=%0d buf_idx=%0d want %0d %0d", buf_ctr, buf_idx, exp_ctr, exp_idx);
      end
   endtask

   task automatic test_ring();
      send_sample();
      repeat (20) @(posedge adc_clk);
      send_sample();
      drain();
      tests++;
      if (buf_ctr !== 16'd2 || buf_idx !== 1'b0) begin
         fails++; $display("FAIL ring_ctrs: buf_ctr=%0d buf_idx=%0d want 2 0", buf_ctr, buf_idx);
      end
   endtask

   task automatic test_ovfl();
      int w0;
      logic [47:0] tk;
      w0 = n_wr;
      send_sample();
      repeat (3) @(posedge adc_clk);
      pulse(tk);
      drain();
      tests++;
      if (n_wr - w0 != 8) begin fails++; $display("FAIL ovfl_writes: %0d writes want 8", n_wr - w0); end
      tests++;
      if (ovfl !== 1'b1) begin fails++; $display("FAIL ovfl_set: ovfl=%b want 1", ovfl); end
      send_sample();
      drain();
      tests++;
      if (ovfl !== 1'b1 || buf_ctr !== 16'd3) begin
         fails++; $display("FAIL ovfl_sticky: ovfl=%b buf_ctr=%0d want 1 3", ovfl, buf_ctr);
      end
   endtask

   task automatic test_abort();
      int w0, b;
      logic [47:0] tk;
      sb_en = 0;
      pulse(tk);
      b = 0;
      while (rd_getQ !== 1'b1 && b < 40) begin @(negedge adc_clk); b++; end
      tests++;
      if (rd_getQ !== 1'b1) begin fails++; $display("FAIL abort_getq: rd_getQ never seen"); end
      repeat (4) @(posedge adc_clk);
      #1 buf_rst = 1;
      @(posedge adc_clk); #1 buf_rst = 0;
      w0 = n_wr;
      repeat (20) @(negedge adc_clk);
      tests++;
      if (n_wr != w0) begin fails++; $display("FAIL abort_wr: %0d writes after buf_rst want 0", n_wr - w0); end
      tests++;
      if (buf_ctr !== 16'd0 || buf_idx !== 1'b0 || ovfl !== 1'b0) begin
         fails++; $display("FAIL abort_clr: buf_ctr=%0d buf_idx=%0d ovfl=%b want 0 0 0", buf_ctr, buf_idx, ovfl);
      end
      model_clear();
      sb_en = 1;
      send_sample();
      drain();
   endtask

   task automatic test_disabled();
      int w0, g0, b;
      logic [47:0] tk;
      nrx_samps = 8'd0;
      w0 = n_wr;
      g0 = n_get;
      for (int i = 0; i < 3; i++) begin pulse(tk); repeat (5) @(posedge adc_clk); end
      repeat (10) @(negedge adc_clk);
      tests++;
      if (n_wr != w0 || n_get != g0 || ovfl !== 1'b0) begin
         fails++; $display("FAIL disabled: writes=%0d gets=%0d ovfl=%b want 0 0 0", n_wr - w0, n_get - g0, ovfl);
      end
      buf_rst_pulse();
      model_clear();
      nrx_samps = 8'd1;
      sb_en = 0;
      pulse(tk);
      b = 0;
      while (rd_getI !== 1'b1 && b < 20) begin @(negedge adc_clk); b++; end
      repeat (13) @(posedge adc_clk);
      #2;
      tests++;
      if (mem_wr !== 1'b1) begin fails++; $display("FAIL ts_active: mem_wr=%b want 1 during tick stamp", mem_wr); end
      reset = 1;
      #1;
      tests++;
      if ({rd_getI, rd_getQ, mem_wr, mem_waddr, mem_wdata, srq, buf_idx, buf_ctr, ovfl} !== '0) begin
         fails++; $display("FAIL async_rst: outputs not zero right after reset, mem_wr=%b mem_waddr=%0d", mem_wr, mem_waddr);
      end
      @(negedge adc_clk); reset = 0;
      model_clear();
      sb_en = 1;
   endtask

   task automatic test_wrap();
      int w0, g0;
      nrx_samps = 8'd8;
      for (int i = 0; i < 8; i++) begin send_sample(); repeat (14) @(posedge adc_clk); end
      drain();
      tests++;
      if (buf_ctr !== 16'd1 || buf_idx !== 1'b1) begin
         fails++; $display("FAIL wrap_ctrs: buf_ctr=%0d buf_idx=%0d want 1 1", buf_ctr, buf_idx);
      end
      w0 = n_wr;
      g0 = n_get;
      @(posedge adc_clk); #1 begin rx_avail = 1; buf_rst = 1; end
      @(posedge adc_clk); #1 begin rx_avail = 0; buf_rst = 0; end
      repeat (15) @(negedge adc_clk);
      tests++;
      if (n_wr != w0 || n_get != g0 || buf_ctr !== 16'd0 || buf_idx !== 1'b0) begin
         fails++; $display("FAIL rst_wins: writes=%0d gets=%0d buf_ctr=%0d want 0 0 0", n_wr - w0, n_get - g0, buf_ctr);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fill();
      test_ring();
      test_ovfl();
      test_abort();
      test_disabled();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
